// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, cause-bit
// positions and counter sizing helpers.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        POR_HOLD  = 2'd1,
        SYS_HOLD  = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_LOCK = 1;
    localparam int CAUSE_BTN  = 2;
    localparam int CAUSE_SOFT = 3;
    localparam int CAUSE_W    = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_RESET = CAUSE_W'(1 << CAUSE_POR);

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, consecutive-sample debounce
// and a one-cycle pulse on each debounced press.
module rst_debounce
    import rst_seq_pkg::*;
#(
    parameter int DBNC_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = cnt_width(DBNC_CYCLES);

    logic          sync1_q, sync1_d;
    logic          btn_s_q, btn_s_d;
    logic          btn_db_q, btn_db_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = sync1_q;
        btn_s_d  = btn_s_q;
        btn_db_d = btn_db_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (en_i) begin
            sync1_d = btn_i;
            btn_s_d = sync1_q;
            if (btn_s_q != btn_db_q) begin
                if (cnt_q == CW'(DBNC_CYCLES - 1)) begin
                    btn_db_d = btn_s_q;
                    cnt_d    = '0;
                    press_d  = btn_s_q;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            btn_db_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            btn_s_q  <= btn_s_d;
            btn_db_q <= btn_db_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged PORESETn/SYSRESETn sequencer with PLL lock qualification, button
// reset, warm reset on SYSRESETREQ and a sticky reset-cause register.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int POR_HOLD_CYCLES    = 255,
    parameter int SYS_HOLD_CYCLES    = 16,
    parameter int DBNC_CYCLES        = 100000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PLL_LOCKED,
    input  logic               BTN,
    input  logic               SYSRESETREQ,
    input  logic               RST_CAUSE_CLR,
    output logic               PORESETn,
    output logic               SYSRESETn,
    output logic [CAUSE_W-1:0] RST_CAUSE
);

    localparam int CNT_W = cnt_width(max3(LOCK_STABLE_CYCLES, POR_HOLD_CYCLES, SYS_HOLD_CYCLES));

    logic               arm_q;
    logic               lock_s1_q, lock_s_q;
    logic               req_q, req_prev_q;
    logic               soft_req, btn_press;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [CAUSE_W-1:0] cause_q, cause_d, cause_set;
    logic               por_q, sys_q;

    rst_debounce #(
        .DBNC_CYCLES(DBNC_CYCLES)
    ) u_btn (
        .clk     (CLK),
        .rst     (RESET),
        .en_i    (arm_q),
        .btn_i   (BTN),
        .press_o (btn_press)
    );

    assign soft_req = req_q & ~req_prev_q;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_set = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (!lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = POR_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            POR_HOLD: begin
                if (cnt_q == CNT_W'(POR_HOLD_CYCLES - 1)) begin
                    state_d = SYS_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SYS_HOLD: begin
                if (cnt_q == CNT_W'(SYS_HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: cnt_d = '0;
        endcase

        // Every observed event records its cause, even when a higher-priority one wins.
        if (state_q != WAIT_LOCK) begin
            if (!lock_s_q) begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end else if (btn_press) begin
                state_d = POR_HOLD;
                cnt_d   = '0;
            end else if (state_q == RUN && soft_req) begin
                state_d = SYS_HOLD;
                cnt_d   = '0;
            end
            cause_set[CAUSE_LOCK] = ~lock_s_q;
            cause_set[CAUSE_BTN]  = btn_press;
            cause_set[CAUSE_SOFT] = (state_q == RUN) && soft_req;
        end

        cause_d = (RST_CAUSE_CLR ? '0 : cause_q) | cause_set;
    end

    // The first edge after RESET release only arms the block, so no state flop
    // captures data on an edge that may sit inside the deassertion recovery window.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            arm_q      <= 1'b0;
            lock_s1_q  <= 1'b0;
            lock_s_q   <= 1'b0;
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            cause_q    <= CAUSE_RESET;
            por_q      <= 1'b0;
            sys_q      <= 1'b0;
        end else begin
            arm_q <= 1'b1;
            if (arm_q) begin
                lock_s1_q  <= PLL_LOCKED;
                lock_s_q   <= lock_s1_q;
                req_q      <= SYSRESETREQ;
                req_prev_q <= req_q;
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                cause_q    <= cause_d;
                por_q      <= (state_d == SYS_HOLD) || (state_d == RUN);
                sys_q      <= (state_d == RUN);
            end
        end
    end

    assign PORESETn  = por_q;
    assign SYSRESETn = sys_q;
    assign RST_CAUSE = cause_q;

endmodule
